mem_req_master: RTL
===================

// Module: mem_req_master
// PURPOSE
//  Initiator side of the data-memory port. It takes one load or store per request from the
//  MEM stage and drives a req/ack memory bus. The responding memory may take a variable
//  number of wait states. While a transaction is outstanding, the block stalls the pipeline.
//  The read result is returned with a one-cycle valid strobe. A watchdog aborts any
//  transaction that receives no ack.
// PARAMETERS
//  ADDR_W   24   memory address width; m_addr = req_addr[ADDR_W-1:0]
//  DATA_W   32   data width of pipeline and memory bus
//  TMO_W    8    watchdog counter width; abort after 2**TMO_W-1 cycles without ack
// PORTS
//  clk        in   1        rising-edge clock
//  clear      in   1        asynchronous, active-low reset
//  req_rd     in   1        load request (level, sampled in IDLE)
//  req_wr     in   1        store request (level, sampled in IDLE)
//  req_addr   in   32       byte-agnostic word address from ALU
//  req_wdata  in   DATA_W   store data
//  stall      out  1        hold pipeline; combinational as described below
//  rd_data    out  DATA_W   load result, held until next load completes
//  rd_valid   out  1        1-cycle pulse: rd_data updated
//  err        out  1        1-cycle pulse: request rejected or timed out
//  m_req      out  1        bus request, registered
//  m_we       out  1        1=write, 0=read; valid while m_req
//  m_addr     out  ADDR_W   bus address; valid while m_req
//  m_wdata    out  DATA_W   bus write data; valid while m_req && m_we
//  m_ack      in   1        responder ack; one-cycle pulse, sampled on clk
//  m_rdata    in   DATA_W   read data; valid in the cycle m_ack=1 && !m_we
// BEHAVIOUR
//  Reset (clear=0, asynchronous): state=IDLE. m_req, m_we, rd_valid and err are 0.
//   m_addr, m_wdata, rd_data and the watchdog counter are 0. Reset asserted mid-transaction
//   drops m_req immediately and discards the transaction; no rd_valid or err is generated.
//  FSM states: IDLE, BUSY.
//  IDLE:
//   - If req_rd^req_wr=1 and req_addr[31:ADDR_W]==0: latch addr, wdata and we=req_wr,
//     then go to BUSY. m_req=1 from the next cycle.
//   - If req_rd&req_wr=1, or any of req_addr[31:ADDR_W]!=0: no bus access. err pulses next
//     cycle; stay in IDLE.
//  BUSY:
//   - m_req, m_we, m_addr and m_wdata are held stable. req_* inputs are ignored.
//   - Watchdog increments every cycle.
//   - On m_ack=1: m_req drops at that edge; go to IDLE; counter cleared. For a read,
//     rd_data<=m_rdata and rd_valid=1 for exactly one cycle.
//   - Watchdog reaching 2**TMO_W-1 with no ack: m_req drops; err pulses; rd_data is
//     unchanged; go to IDLE.
//  stall:
//   - 1 in IDLE when req_rd|req_wr=1 (including rejected requests, for that one cycle).
//   - 1 throughout BUSY.
//   - 0 in the cycle after ack or timeout.
//  Latency: request seen at edge N; m_req=1 in N..; ack sampled at edge N+1+W (W wait
//   states >= 0). Minimum 2-cycle stall for a zero-wait responder.
//  Back-to-back: a new request can be accepted in the first IDLE cycle after completion.
//   m_req is low for at least one cycle between transactions.
//  m_ack while in IDLE is ignored (spurious; no output change).
//  Ack and timeout in the same cycle: ack wins; the transaction completes normally and
//   there is no err.
// TESTING
//  1 Store: req_wr=1, addr=0x10, wdata=0xDEADBEEF, responder acks after 0 waits
//     -> one m_req with m_we=1 and m_addr=0x10; stall high for 2 cycles; no rd_valid.
//  2 Load with 3 wait states, m_rdata=0x12345678 -> m_req high for 4 cycles; rd_data is
//     0x12345678 with one rd_valid pulse; stall drops the cycle after ack.
//  3 req_rd=req_wr=1, then addr=0x0100_0000 -> no m_req in either case; err pulses once
//     per request; stall high for 1 cycle.
//  4 Load, responder never acks, TMO_W=4 -> m_req drops after 15 cycles; err pulse;
//     rd_data keeps its previous value.
//  5 clear pulled low 2 cycles into a load -> m_req=0 asynchronously; all outputs 0; the
//     first request after release runs normally.
//  6 Two loads back-to-back, zero waits -> m_req low for at least 1 cycle between them;
//     two rd_valid pulses carrying the correct data.

Source files
------------

// File: rtl/mem_req_master_if.sv
// Memory bus between the data-memory initiator and its responder.
//   m_req   initiator -> responder  registered bus request
//   m_we    initiator -> responder  1=write, 0=read (valid while m_req)
//   m_addr  initiator -> responder  word address (valid while m_req)
//   m_wdata initiator -> responder  write data (valid while m_req && m_we)
//   m_ack   responder -> initiator  one-cycle completion pulse
//   m_rdata responder -> initiator  read data (valid with m_ack on a read)
interface mem_req_master_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/mem_req_master.sv
// Data-memory port initiator. Accepts one load or store from the MEM stage,
// runs it on the req/ack bus, stalls the pipeline while it is outstanding,
// returns load data with a one-cycle rd_valid strobe and aborts through a
// watchdog when the responder never acks.
// Ports:
//   clk        rising-edge clock
//   clear      asynchronous active-low reset
//   req_rd     load request (level, sampled while idle)
//   req_wr     store request (level, sampled while idle)
//   req_addr   32-bit word address; bits above ADDR_W must be zero
//   req_wdata  store data
//   stall      combinational pipeline hold
//   rd_data    last load result, held until the next load completes
//   rd_valid   one-cycle pulse when rd_data is updated
//   err        one-cycle pulse on a rejected request or a timeout
//   bus        memory bus, master side
module mem_req_master #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err,
  mem_req_master_if.master  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  // The counter holds the number of completed BUSY cycles; when it shows
  // 2**TMO_W-2 the current cycle is the last one allowed, so an edge without
  // ack here is the (2**TMO_W-1)-th cycle with no response.
  localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t              state_p0, state_d;
  logic [TMO_W-1:0]    cnt_p0, cnt_d;
  logic                req_p0;
  logic                we_p0;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;

  logic                addr_ok;
  logic                accept;
  logic                reject;
  logic                done_ack;
  logic                timeout;

  assign addr_ok = ((req_addr >> ADDR_W) == 32'd0);

  always_comb begin
    state_d  = state_p0;
    cnt_d    = cnt_p0;
    accept   = 1'b0;
    reject   = 1'b0;
    done_ack = 1'b0;
    timeout  = 1'b0;
    stall    = 1'b0;
    case (state_p0)
      IDLE: begin
        cnt_d = '0;
        stall = req_rd | req_wr;
        if ((req_rd ^ req_wr) && addr_ok) begin
          accept  = 1'b1;
          state_d = BUSY;
        end else if (req_rd | req_wr) begin
          reject = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_p0 + TMO_W'(1);
        // Ack takes priority over an expiring watchdog in the same cycle.
        if (bus.m_ack) begin
          done_ack = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_p0 == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---- stage p0: control state, bus registers, response strobes ----
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      req_p0   <= 1'b0;
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_p0 <= state_d;
      cnt_p0   <= cnt_d;
      rd_valid <= done_ack & ~we_p0;
      err      <= reject | timeout;
      if (accept) begin
        req_p0   <= 1'b1;
        we_p0    <= req_wr;
        addr_p0  <= req_addr[ADDR_W-1:0];
        wdata_p0 <= req_wdata;
      end else if (done_ack || timeout) begin
        req_p0 <= 1'b0;
      end
      if (done_ack && !we_p0) begin
        rd_data <= bus.m_rdata;
      end
    end
  end

  assign bus.m_req   = req_p0;
  assign bus.m_we    = we_p0;
  assign bus.m_addr  = addr_p0;
  assign bus.m_wdata = wdata_p0;

endmodule
